nes_vga_scanout: RTL and testbench

- Display-side stage directly downstream of the hq2x line-doubler.
- Generates 640x480@60 VGA timing and drives the doubler's read_x.
- Places the 512x480 doubled NES image centred, with a black border, and emits aligned sync, DE and RGB555.
- Starts scanning only after the doubler reports a frame is available, so the output frame locks to the emulated frame.

---
 rtl/nes_video_pkg.sv | 34 +++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 rtl/nes_vga_scanout.sv | 130 +++++++++++++
 tb/tb_nes_vga_scanout.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_video_pkg.sv
// nes_video_pkg: shared pixel type, default 640x480@60 timing, the NES image
// window and small helpers used by the NES video output path.
package nes_video_pkg;

    typedef logic [14:0] rgb555_t;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_IMG_X0   = 64;
    localparam int DEF_IMG_W    = 512;
    localparam int DEF_RD_LAT   = 1;

    // Length of a full line or frame from its four timing segments.
    function automatic int timing_total(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // 75% brightness with truncating shifts, used for the scanline effect.
    function automatic logic [4:0] scanline_dim(input logic [4:0] c);
        return (c >> 1) + (c >> 2);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: WAIT/RUN frame lock plus the horizontal/vertical counters.
// Produces undelayed hs/vs/de/in_img decodes for the current counter position,
// the doubler column/row for that position and the line_pair buffer-swap cue.
module vga_timing_gen
    import nes_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_X0   = DEF_IMG_X0,
    parameter int IMG_W    = DEF_IMG_W
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce_pix,
    input  logic       i_frame_available,
    output logic       o_locked,
    output logic       o_line_pair,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_de,
    output logic       o_in_img,
    output logic       o_row,
    output logic [8:0] o_col
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_BEGIN = HW'(IMG_X0);
    localparam logic [HW-1:0] IMG_END   = HW'(IMG_X0 + IMG_W);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic [HW-1:0] r_h_cnt;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] r_v_cnt;
    logic [VW-1:0] w_v_next;
    logic          r_line_pair;
    logic          w_line_pair_next;
    logic          w_run;

    // State, counters and the line-pair pulse; reset returns straight to WAIT at the origin.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_WAIT;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_line_pair <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_h_cnt     <= w_h_next;
            r_v_cnt     <= w_v_next;
            r_line_pair <= w_line_pair_next;
        end
    end

    // WAIT parks at the origin until the doubler has a frame; RUN scans exactly one frame, then re-arms.
    always_comb begin
        w_state_next     = r_state;
        w_h_next         = r_h_cnt;
        w_v_next         = r_v_cnt;
        w_line_pair_next = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_h_next = '0;
                w_v_next = '0;
                if (i_frame_available) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_ce_pix) begin
                    if (r_h_cnt == H_LAST) begin
                        w_h_next         = '0;
                        w_line_pair_next = r_v_cnt[0] && (r_v_cnt < V_ACT_END);
                        if (r_v_cnt == V_LAST) begin
                            w_v_next     = '0;
                            w_state_next = ST_WAIT;
                        end else begin
                            w_v_next = r_v_cnt + VW'(1);
                        end
                    end else begin
                        w_h_next = r_h_cnt + HW'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
    end

    assign w_run       = (r_state == ST_RUN);
    assign o_locked    = w_run;
    assign o_line_pair = r_line_pair;

    // Every decode is gated by RUN so WAIT looks exactly like the reset state downstream.
    assign o_de     = w_run && (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign o_hs     = !(w_run && (r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_END));
    assign o_vs     = !(w_run && (r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_END));
    assign o_in_img = w_run && (r_h_cnt >= IMG_BEGIN) && (r_h_cnt < IMG_END)
                      && (r_v_cnt < V_ACT_END);
    assign o_row    = r_v_cnt[0];
    assign o_col    = 9'(r_h_cnt - IMG_BEGIN);

endmodule

// File: rtl/nes_vga_scanout.sv
// nes_vga_scanout: VGA scan-out stage behind the hq2x line doubler. Drives the
// doubler read address, delays sync/DE/image-window flags to line up with the
// returned pixel and emits blanked, centred RGB555 with aligned syncs.
// Optional build macro NES_SCANOUT_SCANLINES_EN dims odd output lines to 75%.
// RD_LAT must be at least 1.
module nes_vga_scanout
    import nes_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_X0   = DEF_IMG_X0,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce_pix,
    input  logic        i_frame_available,
    input  logic [14:0] i_pixel_in,
    output logic [9:0]  o_read_x,
    output logic        o_locked,
    output logic        o_line_pair,
    output logic        o_vga_hs,
    output logic        o_vga_vs,
    output logic        o_vga_de,
    output logic [4:0]  o_vga_r,
    output logic [4:0]  o_vga_g,
    output logic [4:0]  o_vga_b
);

    logic        w_hs;
    logic        w_vs;
    logic        w_de;
    logic        w_in_img;
    logic        w_row;
    logic [8:0]  w_col;

    logic [9:0]        r_read_x;
    logic [RD_LAT:0]   r_hs_pipe;
    logic [RD_LAT:0]   r_vs_pipe;
    logic [RD_LAT:0]   r_de_pipe;
    logic [RD_LAT:0]   r_img_pipe;
`ifdef NES_SCANOUT_SCANLINES_EN
    logic [RD_LAT:0]   r_odd_pipe;
`endif

    rgb555_t     w_pix;
    logic [4:0]  w_r;
    logic [4:0]  w_g;
    logic [4:0]  w_b;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_X0   (IMG_X0),
        .IMG_W    (IMG_W)
    ) u_timing (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_ce_pix          (i_ce_pix),
        .i_frame_available (i_frame_available),
        .o_locked          (o_locked),
        .o_line_pair       (o_line_pair),
        .o_hs              (w_hs),
        .o_vs              (w_vs),
        .o_de              (w_de),
        .o_in_img          (w_in_img),
        .o_row             (w_row),
        .o_col             (w_col)
    );

    // Stage 0 issues the read address; the flags then ride RD_LAT more stages so they meet the pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_x   <= '0;
            r_hs_pipe  <= '1;
            r_vs_pipe  <= '1;
            r_de_pipe  <= '0;
            r_img_pipe <= '0;
`ifdef NES_SCANOUT_SCANLINES_EN
            r_odd_pipe <= '0;
`endif
        end else if (i_ce_pix) begin
            r_read_x   <= w_in_img ? {w_row, w_col} : 10'd0;
            r_hs_pipe  <= {r_hs_pipe[RD_LAT-1:0], w_hs};
            r_vs_pipe  <= {r_vs_pipe[RD_LAT-1:0], w_vs};
            r_de_pipe  <= {r_de_pipe[RD_LAT-1:0], w_de};
            r_img_pipe <= {r_img_pipe[RD_LAT-1:0], w_in_img};
`ifdef NES_SCANOUT_SCANLINES_EN
            r_odd_pipe <= {r_odd_pipe[RD_LAT-1:0], w_row};
`endif
        end
    end

    // Final colour stage is combinational on the doubler's registered pixel so it adds no latency.
    always_comb begin
        w_pix = r_img_pipe[RD_LAT] ? i_pixel_in : '0;
        w_r   = w_pix[4:0];
        w_g   = w_pix[9:5];
        w_b   = w_pix[14:10];
`ifdef NES_SCANOUT_SCANLINES_EN
        if (r_odd_pipe[RD_LAT]) begin
            w_r = scanline_dim(w_r);
            w_g = scanline_dim(w_g);
            w_b = scanline_dim(w_b);
        end
`endif
    end

    assign o_read_x = r_read_x;
    assign o_vga_hs = r_hs_pipe[RD_LAT];
    assign o_vga_vs = r_vs_pipe[RD_LAT];
    assign o_vga_de = r_de_pipe[RD_LAT];
    assign o_vga_r  = w_r;
    assign o_vga_g  = w_g;
    assign o_vga_b  = w_b;

endmodule

// File: tb/tb_nes_vga_scanout.sv
// tb_nes_vga_scanout: randomized bench for nes_vga_scanout using a reduced
// timing set so several whole frames fit in a short run. A positional model
// (ticks since frame start -> h,v) predicts every output on every cycle.
module tb_nes_vga_scanout;

    localparam int HA    = 40;
    localparam int HFP   = 4;
    localparam int HSW   = 6;
    localparam int HBP   = 6;
    localparam int VA    = 20;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int VBP   = 3;
    localparam int X0    = 8;
    localparam int W     = 24;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

`ifdef NES_SCANOUT_SCANLINES_EN
    localparam logic [14:0] LIT_FIRST = 15'h0180;
    localparam logic [14:0] LIT_LAST  = 15'h0190;
`else
    localparam logic [14:0] LIT_FIRST = 15'h0200;
    localparam logic [14:0] LIT_LAST  = 15'h0217;
`endif

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        ce         = 1'b0;
    logic        frameAvail = 1'b0;
    logic [14:0] pixelIn    = '0;
    logic [9:0]  readX;
    logic        locked;
    logic        linePair;
    logic        vgaHs;
    logic        vgaVs;
    logic        vgaDe;
    logic [4:0]  vgaR;
    logic [4:0]  vgaG;
    logic [4:0]  vgaB;

    int checks   = 0;
    int errors   = 0;
    int ceMode   = 0;
    int ceCnt    = 0;
    bit checking = 1'b0;
    bit lutIdentity = 1'b1;
    logic [14:0] lut [1024];

    bit mRun = 1'b0;
    int mN   = 0;
    int mP1  = -1;
    int mP2  = -1;
    bit mLp  = 1'b0;

    int deTicks = 0;
    int hsLow   = 0;
    int vsLow   = 0;
    int lpCount = 0;
    int frames  = 0;

    always #5 clk = ~clk;

    nes_vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .IMG_X0   (X0), .IMG_W (W),  .RD_LAT (1)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_ce_pix          (ce),
        .i_frame_available (frameAvail),
        .i_pixel_in        (pixelIn),
        .o_read_x          (readX),
        .o_locked          (locked),
        .o_line_pair       (linePair),
        .o_vga_hs          (vgaHs),
        .o_vga_vs          (vgaVs),
        .o_vga_de          (vgaDe),
        .o_vga_r           (vgaR),
        .o_vga_g           (vgaG),
        .o_vga_b           (vgaB)
    );

    // Doubler stand-in: one ce_pix tick from read_x to pixel_in, contents from a lookup table.
    always @(posedge clk) begin
        if (ce) pixelIn <= lut[readX];
    end

    // Pixel-enable pattern: every clock, every 4th clock, or random.
    always @(negedge clk) begin
        ceCnt++;
        case (ceMode)
            0:       ce = 1'b1;
            1:       ce = (ceCnt % 4 == 0);
            default: ce = 1'($urandom_range(0, 1));
        endcase
    end

    // Positions are ticks since frame start, -1 meaning blank; pins show the position two ticks back.
    function automatic bit posDe(input int p);
        return (p >= 0) && (p % HT < HA) && (p / HT < VA);
    endfunction

    function automatic bit posHs(input int p);
        return !((p >= 0) && (p % HT >= HA + HFP) && (p % HT < HA + HFP + HSW));
    endfunction

    function automatic bit posVs(input int p);
        return !((p >= 0) && (p / HT >= VA + VFP) && (p / HT < VA + VFP + VSW));
    endfunction

    function automatic bit posImg(input int p);
        return (p >= 0) && (p % HT >= X0) && (p % HT < X0 + W) && (p / HT < VA);
    endfunction

    function automatic int addrOf(input int p);
        if (!posImg(p)) return 0;
        return ((p / HT) % 2) * 512 + (p % HT - X0);
    endfunction

    function automatic logic [14:0] posRgb(input int p);
        logic [14:0] px;
`ifdef NES_SCANOUT_SCANLINES_EN
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
`endif
        if (!posImg(p)) return 15'h0;
        px = lut[addrOf(p)];
`ifdef NES_SCANOUT_SCANLINES_EN
        if ((p / HT) % 2 == 1) begin
            r  = px[4:0];
            g  = px[9:5];
            b  = px[14:10];
            r  = 5'((r / 2) + (r / 4));
            g  = 5'((g / 2) + (g / 4));
            b  = 5'((b / 2) + (b / 4));
            px = {b, g, r};
        end
`endif
        return px;
    endfunction

    // Reference model: frame lock, tick position and the line-pair cue, advanced on each clock edge.
    always @(posedge clk) begin : model
        bit was;
        was = mRun;
        if (reset) begin
            mRun = 1'b0;
            mN   = 0;
            mP1  = -1;
            mP2  = -1;
            mLp  = 1'b0;
        end else begin
            mLp = 1'b0;
            if (ce) begin
                mP2 = mP1;
                mP1 = was ? mN : -1;
                if (was) begin
                    if ((mN % HT == HT - 1) && ((mN / HT) % 2 == 1) && (mN / HT < VA)) mLp = 1'b1;
                    mN++;
                    if (mN == FRAME) begin
                        mN   = 0;
                        mRun = 1'b0;
                    end
                end
            end
            if (!was && frameAvail) mRun = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fa, input int cycles);
        reset      = rst;
        frameAvail = fa;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitFrameEnd(input int budget, output int cyc);
        cyc = 0;
        while (locked === 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_end locked=%b still high after %0d clks", locked, cyc);
        end
    endtask

    // Per-cycle comparison against the model plus frame totals and pinned identity-table pixels.
    always @(posedge clk) begin : compare
        logic [14:0] rgbAct;
        bit tick;
        #1;
        if (checking) begin
            rgbAct = {vgaB, vgaG, vgaR};
            tick   = ce && !reset;
            checks++;
            if (vgaDe !== posDe(mP2) || vgaHs !== posHs(mP2) || vgaVs !== posVs(mP2) ||
                rgbAct !== posRgb(mP2) || readX !== 10'(addrOf(mP1)) ||
                locked !== mRun || linePair !== mLp) begin
                errors++;
                if (errors <= 10)
                    $display("[TB] FAIL pins t=%0t pos=%0d (actual/expected) de=%b/%b hs=%b/%b vs=%b/%b rgb=%h/%h rx=%h/%h lock=%b/%b lp=%b/%b",
                             $time, mP2, vgaDe, posDe(mP2), vgaHs, posHs(mP2), vgaVs, posVs(mP2),
                             rgbAct, posRgb(mP2), readX, 10'(addrOf(mP1)), locked, mRun, linePair, mLp);
            end
            if (reset) begin
                deTicks = 0; hsLow = 0; vsLow = 0; lpCount = 0;
            end
            if (tick && mP2 == 0) begin
                deTicks = 0; hsLow = 0; vsLow = 0; lpCount = 0;
            end
            if (linePair === 1'b1) lpCount++;
            if (tick) begin
                if (vgaDe === 1'b1) deTicks++;
                if (vgaHs === 1'b0) hsLow++;
                if (vgaVs === 1'b0) vsLow++;
                if (lutIdentity) begin
                    if (mP2 == 3 * HT + X0)         checkOutput("pix_first_v3", 32'(rgbAct), 32'(LIT_FIRST));
                    if (mP2 == 3 * HT + X0 + W - 1) checkOutput("pix_last_col", 32'(rgbAct), 32'(LIT_LAST));
                    if (mP2 == 3 * HT + X0 + W)     checkOutput("pix_after_img", {16'h0, vgaDe, rgbAct}, 32'h8000);
                end
                if (mP2 == FRAME - 1) begin
                    frames++;
                    checkOutput("frame_de_ticks", deTicks, HA * VA);
                    checkOutput("frame_hs_low", hsLow, HSW * VT);
                    checkOutput("frame_vs_low", vsLow, VSW * HT);
                    checkOutput("frame_line_pairs", lpCount, VA / 2);
                end
            end
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) lut[i] = 15'(i);
        repeat (3) @(negedge clk);
        checking = 1'b1;
        checkOutput("reset_locked", {31'h0, locked}, 32'h0);
        checkOutput("reset_hs", {31'h0, vgaHs}, 32'h1);
        checkOutput("reset_vs", {31'h0, vgaVs}, 32'h1);
        checkOutput("reset_de", {31'h0, vgaDe}, 32'h0);
        checkOutput("reset_read_x", {22'h0, readX}, 32'h0);
        checkOutput("reset_rgb", {17'h0, vgaB, vgaG, vgaR}, 32'h0);

        // Frame 1: ce every clock, identity table, idle 100 clocks before the frame is offered.
        applyStimulus(1'b0, 1'b0, 100);
        checkOutput("idle_locked", {31'h0, locked}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("locked_after_fa", {31'h0, locked}, 32'h1);
        applyStimulus(1'b0, 1'b0, 0);
        waitFrameEnd(FRAME + 50, cyc);
        checkOutput("frame1_clocks", cyc, FRAME);

        // Frame 2: ce every 4th clock with random pixel contents.
        lutIdentity = 1'b0;
        for (int i = 0; i < 1024; i++) lut[i] = 15'($urandom);
        ceMode = 1;
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 0);
        waitFrameEnd(4 * FRAME + 50, cyc);
        checks++;
        if (cyc < 4 * FRAME - 8 || cyc > 4 * FRAME + 4) begin
            errors++;
            $display("[TB] FAIL frame2_clocks actual=%0d expected=%0d..%0d", cyc, 4 * FRAME - 8, 4 * FRAME + 4);
        end

        // Frame 3: random ce, frame_available held for a random stretch that overlaps RUN.
        ceMode = 2;
        applyStimulus(1'b0, 1'b0, 7);
        applyStimulus(1'b0, 1'b1, $urandom_range(1, 30));
        applyStimulus(1'b0, 1'b0, 0);
        waitFrameEnd(8 * FRAME, cyc);

        // Mid-frame reset, then a fresh frame must restart from the origin.
        for (int i = 0; i < 1024; i++) lut[i] = 15'($urandom);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 0);
        cyc = 0;
        while (!(mRun && mN == 10 * HT + 20) && cyc < 8 * FRAME) begin
            @(negedge clk);
            cyc++;
        end
        if (!(mRun && mN == 10 * HT + 20)) begin
            errors++;
            $display("[TB] FAIL reach_reset_point actual_pos=%0d expected_pos=%0d", mN, 10 * HT + 20);
        end
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("midreset_de", {31'h0, vgaDe}, 32'h0);
        checkOutput("midreset_hs", {31'h0, vgaHs}, 32'h1);
        checkOutput("midreset_vs", {31'h0, vgaVs}, 32'h1);
        checkOutput("midreset_locked", {31'h0, locked}, 32'h0);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("post_reset_idle", {31'h0, locked}, 32'h0);
        ceMode = 0;
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 0);
        waitFrameEnd(FRAME + 50, cyc);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("full_frames", frames, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
